// File: rtl/fifo_rd_axis_adapter_pkg.sv
// Shared constants and helpers for the FIFO read-side AXI-Stream adapter.
// Optional tlast split is controlled by FIFO_RD_ADAPTER_TLAST_EN.
package fifo_rd_axis_adapter_pkg;

    localparam int CNT_W = 2;

    // Held + in-flight entries after this cycle's pop.
    function automatic logic [CNT_W:0] credit_next(
        input logic [CNT_W-1:0] occ,
        input logic             infl,
        input logic             pop
    );
        return {1'b0, occ}
             + {{CNT_W{1'b0}}, infl}
             - {{CNT_W{1'b0}}, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_axis_adapter.sv
// FIFO read port to AXI-Stream master with a 2-entry prefetch buffer.
// Define FIFO_RD_ADAPTER_TLAST_EN to split the data MSB off as m_axis_tlast.
module fifo_rd_axis_adapter
    import fifo_rd_axis_adapter_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    input  logic [DWIDTH-1:0] rd_data,
    input  logic              rd_empty,
`ifdef FIFO_RD_ADAPTER_TLAST_EN
    output logic [DWIDTH-2:0] m_axis_tdata,
    output logic              m_axis_tlast,
`else
    output logic [DWIDTH-1:0] m_axis_tdata,
`endif
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [1:0]        buf_cnt
);

    localparam int DEPTH = 2;

    logic [DWIDTH-1:0] buf_q [DEPTH];
    logic [DWIDTH-1:0] buf_d [DEPTH];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              infl_q, infl_d;
    logic [CNT_W-1:0]  occ_q,  occ_d;
    logic              pop;
    logic [CNT_W:0]    credit;
    logic [DWIDTH-1:0] head_word;

    always_comb begin
        pop    = (occ_q != '0) & m_axis_tready;
        credit = credit_next(occ_q, infl_q, pop);
        // Credit check keeps held + in-flight reads within the buffer depth.
        rd_en  = ~rst & ~rd_empty & (credit < (CNT_W+1)'(DEPTH));
        occ_d  = credit[CNT_W-1:0];
        infl_d = rd_en;
        head_d = head_q ^ pop;
        tail_d = tail_q ^ infl_q;
        buf_d  = buf_q;
        if (infl_q) begin
            buf_d[tail_q] = rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            infl_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            head_q <= head_d;
            tail_q <= tail_d;
            infl_q <= infl_d;
            occ_q  <= occ_d;
        end
    end

    always_comb begin
        head_word     = buf_q[head_q];
        m_axis_tvalid = (occ_q != '0);
        buf_cnt       = occ_q;
`ifdef FIFO_RD_ADAPTER_TLAST_EN
        m_axis_tdata  = head_word[DWIDTH-2:0];
        m_axis_tlast  = head_word[DWIDTH-1];
`else
        m_axis_tdata  = head_word;
`endif
    end

    a_credit_max: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, occ_q} + {{CNT_W{1'b0}}, infl_q}) <= (CNT_W+1)'(DEPTH));

    a_occ_range: assert property (@(posedge clk) disable iff (rst)
        occ_q <= CNT_W'(DEPTH));

    a_no_rd_on_empty: assert property (@(posedge clk) disable iff (rst)
        rd_en |-> !rd_empty);

endmodule

// File: tb/tb_fifo_rd_axis_adapter.sv
// Directed and randomized bench for fifo_rd_axis_adapter with a simple
// registered-output FIFO read model.
`timescale 1ns/1ps
module tb_fifo_rd_axis_adapter;

`ifdef FIFO_RD_ADAPTER_TLAST_EN
    localparam int DW = 65;
    localparam int TW = 64;
`else
    localparam int DW = 64;
    localparam int TW = 64;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          rd_empty;
    logic [TW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic [1:0]    buf_cnt;
`ifdef FIFO_RD_ADAPTER_TLAST_EN
    logic          tlast;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always #5 clk = ~clk;

    assign rd_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en && (wr_ptr != rd_ptr)) begin
            rd_data <= mem[rd_ptr % 4096];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    fifo_rd_axis_adapter #(.DWIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .m_axis_tdata  (tdata),
`ifdef FIFO_RD_ADAPTER_TLAST_EN
        .m_axis_tlast  (tlast),
`endif
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .buf_cnt       (buf_cnt)
    );

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr % 4096] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({tvalid, rd_en, buf_cnt} !== 4'b0) begin
            fails++;
            $display("FAIL reset_init: tvalid/rd_en/buf_cnt=%b expected 0000",
                     {tvalid, rd_en, buf_cnt});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tready = 1'b0;
        for (int i = 0; i < 4; i++) push(DW'(8'hA0 + i));
        repeat (5) @(negedge clk);
        tests++;
        if (buf_cnt !== 2'd2 || tvalid !== 1'b1) begin
            fails++;
            $display("FAIL reset_prefill: buf_cnt=%0d tvalid=%b expected 2 1",
                     buf_cnt, tvalid);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({tvalid, rd_en, buf_cnt} !== 4'b0) begin
            fails++;
            $display("FAIL reset_async: tvalid/rd_en/buf_cnt=%b expected 0000",
                     {tvalid, rd_en, buf_cnt});
        end
        wr_ptr = rd_ptr;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (rd_en !== 1'b0 || tvalid !== 1'b0) begin
                fails++;
                $display("FAIL reset_release c%0d: rd_en=%b tvalid=%b expected 0 0",
                         c, rd_en, tvalid);
            end
        end
    endtask

    task automatic test_basic();
        int first_rd, first_tv, last_bt, beats;
        first_rd = -1;
        first_tv = -1;
        last_bt  = -1;
        beats    = 0;
        @(posedge clk); #1;
        tready = 1'b1;
        for (int i = 1; i <= 8; i++) push(DW'(i));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rd_en && first_rd < 0) first_rd = c;
            if (tvalid) begin
                if (first_tv < 0) first_tv = c;
                tests++;
                if (tdata !== TW'(beats + 1)) begin
                    fails++;
                    $display("FAIL basic_data beat%0d: got %0h expected %0h",
                             beats, tdata, beats + 1);
                end
                beats++;
                last_bt = c;
            end
        end
        tests++;
        if (first_tv - first_rd != 2) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles expected 2",
                     first_tv - first_rd);
        end
        tests++;
        if (beats != 8) begin
            fails++;
            $display("FAIL basic_count: got %0d beats expected 8", beats);
        end
        tests++;
        if (last_bt - first_tv != 7) begin
            fails++;
            $display("FAIL basic_gapless: span %0d expected 7",
                     last_bt - first_tv);
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt, beats;
        logic stable_ok;
        rd_cnt    = 0;
        beats     = 0;
        stable_ok = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
        for (int i = 0; i < 16; i++) push(DW'(8'h10 + i));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_en) rd_cnt++;
            if (tvalid && tdata !== TW'(8'h10)) stable_ok = 1'b0;
        end
        tests++;
        if (rd_cnt != 2) begin
            fails++;
            $display("FAIL bp_rd_pulses: got %0d expected 2", rd_cnt);
        end
        tests++;
        if (buf_cnt !== 2'd2) begin
            fails++;
            $display("FAIL bp_buf_cnt: got %0d expected 2", buf_cnt);
        end
        tests++;
        if (tdata !== TW'(8'h10) || !stable_ok || tvalid !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: tdata=%0h tvalid=%b stable=%b expected 10 1 1",
                     tdata, tvalid, stable_ok);
        end
        @(posedge clk); #1;
        tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tvalid) begin
                tests++;
                if (tdata !== TW'(8'h10 + beats)) begin
                    fails++;
                    $display("FAIL bp_data beat%0d: got %0h expected %0h",
                             beats, tdata, 8'h10 + beats);
                end
                beats++;
            end
        end
        tests++;
        if (beats != 16) begin
            fails++;
            $display("FAIL bp_count: got %0d beats expected 16", beats);
        end
    endtask

    task automatic test_simultaneous();
        int beats;
        beats = 0;
        @(posedge clk); #1;
        tready = 1'b1;
        for (int i = 0; i < 6; i++) push(DW'(8'h20 + i));
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                tests++;
                if (buf_cnt !== 2'd1 || rd_en !== 1'b1) begin
                    fails++;
                    $display("FAIL simul c%0d: buf_cnt=%0d rd_en=%b expected 1 1",
                             c, buf_cnt, rd_en);
                end
            end
            if (tvalid) begin
                tests++;
                if (tdata !== TW'(8'h20 + beats)) begin
                    fails++;
                    $display("FAIL simul_data beat%0d: got %0h expected %0h",
                             beats, tdata, 8'h20 + beats);
                end
                beats++;
            end
        end
        tests++;
        if (beats != 6) begin
            fails++;
            $display("FAIL simul_count: got %0d beats expected 6", beats);
        end
    endtask

    task automatic test_random();
        int base, pushed, got, os, cyc, n;
        logic fill, hold_v, pop;
        logic [TW-1:0] hold_d;
        logic [DW-1:0] v;
        base   = wr_ptr;
        pushed = 0;
        got    = 0;
        os     = 0;
        cyc    = 0;
        fill   = 1'b1;
        hold_v = 1'b0;
        hold_d = '0;
        while (got < 1000 && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            tready = 1'($urandom_range(0, 1));
            if (cyc % 40 == 0) fill = ~fill;
            if (fill) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    if (pushed < 1000) begin
                        v = DW'({$urandom, $urandom, $urandom});
                        push(v);
                        pushed++;
                    end
                end
            end
            @(negedge clk);
            tests++;
            if (rd_en && rd_empty) begin
                fails++;
                $display("FAIL rnd_rd_on_empty cyc%0d: rd_en=1 expected 0", cyc);
            end
            if (hold_v) begin
                tests++;
                if (tvalid !== 1'b1 || tdata !== hold_d) begin
                    fails++;
                    $display("FAIL rnd_stable cyc%0d: got %b/%0h expected 1/%0h",
                             cyc, tvalid, tdata, hold_d);
                end
            end
            pop = tvalid & tready;
            if (pop) begin
                tests++;
                if (tdata !== mem[(base + got) % 4096][TW-1:0]) begin
                    fails++;
                    $display("FAIL rnd_order word%0d: got %0h expected %0h",
                             got, tdata, mem[(base + got) % 4096][TW-1:0]);
                end
                got++;
            end
            os = os + int'(rd_en) - int'(pop);
            tests++;
            if (os > 2 || os < 0) begin
                fails++;
                $display("FAIL rnd_credit cyc%0d: got %0d expected 0..2", cyc, os);
            end
            hold_v = tvalid & ~tready;
            hold_d = tdata;
        end
        tests++;
        if (got != 1000) begin
            fails++;
            $display("FAIL rnd_timeout: got %0d words expected 1000", got);
        end
        @(posedge clk); #1;
        tready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

`ifdef FIFO_RD_ADAPTER_TLAST_EN
    task automatic test_tlast();
        int beats;
        beats = 0;
        @(posedge clk); #1;
        tready = 1'b1;
        push({1'b1, 64'hDEAD});
        push({1'b0, 64'hBEEF});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tvalid) begin
                tests++;
                if (beats == 0 && (tlast !== 1'b1 || tdata !== 64'hDEAD)) begin
                    fails++;
                    $display("FAIL tlast_set: got %b/%0h expected 1/dead",
                             tlast, tdata);
                end
                if (beats == 1 && (tlast !== 1'b0 || tdata !== 64'hBEEF)) begin
                    fails++;
                    $display("FAIL tlast_clr: got %b/%0h expected 0/beef",
                             tlast, tdata);
                end
                beats++;
            end
        end
        tests++;
        if (beats != 2) begin
            fails++;
            $display("FAIL tlast_count: got %0d beats expected 2", beats);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_random();
`ifdef FIFO_RD_ADAPTER_TLAST_EN
        test_tlast();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
